// File: rtl/hamming_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | hamming_pkg: shared Hamming(12,8) constants, FSM type, encoder    |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
package hamming_pkg;

  localparam int HAM_DATA_W = 8;
  localparam int HAM_CODE_W = 12;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int P4_IDX = 3;
  localparam int P8_IDX = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  // Even-parity Hamming(12,8): parity bits at positions 1,2,4,8 (1-based).
  function automatic logic [HAM_CODE_W-1:0] ham_encode(input logic [HAM_DATA_W-1:0] d);
    logic [HAM_CODE_W-1:0] c;
    c         = '0;
    c[11]     = d[7];
    c[10]     = d[6];
    c[9]      = d[5];
    c[8]      = d[4];
    c[6]      = d[3];
    c[5]      = d[2];
    c[4]      = d[1];
    c[2]      = d[0];
    c[P1_IDX] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[P2_IDX] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[P4_IDX] = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[P8_IDX] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_raid_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | hamming_raid_encoder: encodes a host byte and mirrors the codeword |
// | to two drive slots with independent valid/ack and a timeout.      |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
module hamming_raid_encoder
  import hamming_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter bit INJECT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [HAM_DATA_W-1:0] wr_data,
  output logic                  wr_ready,
  input  logic [HAM_CODE_W-1:0] inj_mask_D0,
  input  logic [HAM_CODE_W-1:0] inj_mask_D1,
  output logic [HAM_CODE_W-1:0] enc_data_D0,
  output logic                  enc_valid_D0,
  input  logic                  enc_ack_D0,
  output logic [HAM_CODE_W-1:0] enc_data_D1,
  output logic                  enc_valid_D1,
  input  logic                  enc_ack_D1,
  output logic                  encode_done,
  output logic                  encode_err
);

  enc_state_e state, state_next;

  logic [7:0]            cnt;
  logic                  ready_q;
  logic                  accept;
  logic                  any_pend;
  logic                  last_cycle;
  logic                  abort;
  logic [HAM_CODE_W-1:0] code;
  logic [HAM_CODE_W-1:0] cap   [2];
  logic [HAM_CODE_W-1:0] data_q[2];
  logic [1:0]            vld_q;
  logic [1:0]            ack;

  assign code       = ham_encode(wr_data);
  assign cap[0]     = code ^ (INJECT_EN ? inj_mask_D0 : '0);
  assign cap[1]     = code ^ (INJECT_EN ? inj_mask_D1 : '0);
  assign ack        = {enc_ack_D1, enc_ack_D0};

  assign accept     = wr_valid && ready_q;
  // A slot is still pending after this edge if valid and its ack is not sampled now.
  assign any_pend   = |(vld_q & ~ack);
  assign last_cycle = (cnt == 8'(ACK_TIMEOUT - 1));
  assign abort      = (state == SEND) && any_pend && last_cycle;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (!any_pend || last_cycle) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      cnt         <= '0;
      encode_done <= 1'b0;
      encode_err  <= 1'b0;
    end else begin
      state       <= state_next;
      ready_q     <= (state_next == IDLE);
      cnt         <= (state == SEND) ? cnt + 8'd1 : '0;
      encode_done <= (state == SEND) && !any_pend;
      encode_err  <= abort;
    end
  end

  // Identical handshake for both mirror slots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end else if (accept) begin
        vld_q[i]  <= 1'b1;
        data_q[i] <= cap[i];
      end else if ((state == SEND) && ((vld_q[i] && ack[i]) || abort)) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
    end
  end

  assign wr_ready     = ready_q;
  assign enc_data_D0  = data_q[0];
  assign enc_data_D1  = data_q[1];
  assign enc_valid_D0 = vld_q[0];
  assign enc_valid_D1 = vld_q[1];

endmodule
`default_nettype wire

// File: tb/tb_hamming_raid_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_hamming_raid_encoder: scoreboard bench, two DUTs (inject on/off)|
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
module tb_hamming_raid_encoder;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [11:0] m0 = '0, m1 = '0;
  logic        ack0 = 1'b0, ack1 = 1'b0;

  wire         rdy, v0, v1, done, err;
  wire  [11:0] d0, d1;
  wire         b_rdy, b_v0, b_v1, b_done, b_err;
  wire  [11:0] b_d0, b_d1;

  hamming_raid_encoder #(.ACK_TIMEOUT(T), .INJECT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(rdy),
    .inj_mask_D0(m0), .inj_mask_D1(m1),
    .enc_data_D0(d0), .enc_valid_D0(v0), .enc_ack_D0(ack0),
    .enc_data_D1(d1), .enc_valid_D1(v1), .enc_ack_D1(ack1),
    .encode_done(done), .encode_err(err));

  hamming_raid_encoder #(.ACK_TIMEOUT(T), .INJECT_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(b_rdy),
    .inj_mask_D0(m0), .inj_mask_D1(m1),
    .enc_data_D0(b_d0), .enc_valid_D0(b_v0), .enc_ack_D0(ack0),
    .enc_data_D1(b_d1), .enc_valid_D1(b_v1), .enc_ack_D1(ack1),
    .encode_done(b_done), .encode_err(b_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] c0, c1, clean;
    bit          ok;
    int          dur0, dur1;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Generic Hamming rule: data fills non-power-of-two positions (1-based);
  // parity at position p covers every position whose index has bit p set.
  function automatic logic [11:0] ref_enc(input logic [7:0] d);
    logic [11:0] c;
    int k;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 12; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    for (int p = 1; p <= 8; p = p * 2)
      for (int pos = 1; pos <= 12; pos++)
        if (((pos & p) != 0) && (pos != p)) c[p-1] = c[p-1] ^ c[pos-1];
    return c;
  endfunction

  // Monitor: pops one expectation when a transaction's valids appear, then
  // follows it until the status pulse.
  bit   busy = 1'b0;
  exp_t cur;
  int   n0, n1;
  always @(negedge clk) begin
    if (!reset) begin
      busy = 1'b0;
      q.delete();
    end else begin
      if (!busy && (v0 || v1)) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          cur  = q.pop_front();
          busy = 1'b1;
          n0   = 0;
          n1   = 0;
        end
      end
      if (busy) begin
        if (v0) n0++;
        if (v1) n1++;
        chk("d0_data", d0, v0 ? cur.c0 : 12'h000);
        chk("d1_data", d1, v1 ? cur.c1 : 12'h000);
        chk("noinj_d0_data", b_d0, b_v0 ? cur.clean : 12'h000);
        chk("noinj_d1_data", b_d1, b_v1 ? cur.clean : 12'h000);
        chk("noinj_valids", {b_v0, b_v1}, {v0, v1});
        if (done || err) begin
          chk("status_done", done, cur.ok);
          chk("status_err", err, !cur.ok);
          chk("valid_cycles_d0", n0, cur.dur0);
          chk("valid_cycles_d1", n1, cur.dur1);
          chk("noinj_status", {b_done, b_err}, {done, err});
          busy = 1'b0;
        end
      end else if (done || err || b_done || b_err) begin
        chk("stray_status_pulse", {done, err, b_done, b_err}, 4'b0000);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rdy && n < 50) begin
      step();
      n++;
    end
    if (!rdy) chk("wr_ready_timeout", rdy, 1);
  endtask

  // x0/x1 bit 12 enables a literal codeword check in the first SEND cycle.
  task automatic do_txn(input logic [7:0] dat, input logic [11:0] mk0, input logic [11:0] mk1,
                        input int a0, input int a1, input logic [12:0] x0, input logic [12:0] x1);
    exp_t e;
    int   k;
    wait_ready();
    e.clean = ref_enc(dat);
    e.c0    = e.clean ^ mk0;
    e.c1    = e.clean ^ mk1;
    e.ok    = (a0 >= 1 && a0 <= T) && (a1 >= 1 && a1 <= T);
    e.dur0  = (a0 >= 1 && a0 <= T) ? a0 : T;
    e.dur1  = (a1 >= 1 && a1 <= T) ? a1 : T;
    q.push_back(e);
    wr_valid = 1'b1;
    wr_data  = dat;
    m0       = mk0;
    m1       = mk1;
    step();
    if (x0[12]) chk("literal_d0", d0, x0[11:0]);
    if (x1[12]) chk("literal_d1", d1, x1[11:0]);
    k = 1;
    while (!(done || err)) begin
      if (k > T + 1) begin
        chk("status_timeout", 0, 1);
        break;
      end
      // Junk on the host side while busy must never be taken.
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      m0       = 12'($urandom);
      m1       = 12'($urandom);
      ack0 = (k == a0) || (a0 != 0 && k > a0 && $urandom_range(0, 2) == 0);
      ack1 = (k == a1) || (a1 != 0 && k > a1 && $urandom_range(0, 2) == 0);
      step();
      k++;
    end
    ack0     = 1'b0;
    ack1     = 1'b0;
    wr_valid = 1'b0;
  endtask

  function automatic int rnd_delay();
    if ($urandom_range(0, 9) < 7) return $urandom_range(1, 5);
    return $urandom_range(0, 18);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_wr_ready", rdy, 0);
    chk("rst_valids", {v0, v1}, 2'b00);
    chk("rst_data", {d0, d1}, 24'h0);
    chk("rst_status", {done, err}, 2'b00);
    reset = 1'b1;
    step();
    chk("post_rst_wr_ready", rdy, 1);

    do_txn(8'hA5, 12'h000, 12'h000, 1, 1, 13'h1A27, 13'h1A27);
    do_txn(8'hFF, 12'h000, 12'h000, 1, 1, 13'h1F77, 13'h1F77);
    do_txn(8'h00, 12'h000, 12'h000, 1, 1, 13'h1000, 13'h1000);
    do_txn(8'hA5, 12'h000, 12'h004, 1, 1, 13'h1A27, 13'h1A23);
    do_txn(8'h3C, 12'h000, 12'h000, 2, 5, 13'h0, 13'h0);
    do_txn(8'h5A, 12'h000, 12'h000, 1, 0, 13'h0, 13'h0);
    do_txn(8'h81, 12'h000, 12'h000, 3, T, 13'h0, 13'h0);
    do_txn(8'h7E, 12'h000, 12'h000, T + 1, 2, 13'h0, 13'h0);
    do_txn(8'h11, 12'h800, 12'h001, 0, 0, 13'h0, 13'h0);
    do_txn(8'h22, 12'h000, 12'h000, T, T, 13'h0, 13'h0);
    step();
    chk("ready_after_done", rdy, 1);

    // Abort in SEND: no status pulse for the dropped byte, reset values next cycle.
    wait_ready();
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    step();
    wr_valid = 1'b0;
    reset    = 1'b0;
    step();
    chk("abort_valids", {v0, v1, b_v0, b_v1}, 4'b0000);
    chk("abort_data", {d0, d1}, 24'h0);
    chk("abort_status", {done, err}, 2'b00);
    chk("abort_wr_ready", rdy, 0);
    reset = 1'b1;
    step();
    chk("abort_release_ready", rdy, 1);
    repeat (3) step();

    for (int i = 0; i < 40; i++) begin
      logic [11:0] r0, r1;
      r0 = $urandom_range(0, 1) ? 12'($urandom) : 12'h000;
      r1 = $urandom_range(0, 1) ? 12'($urandom) : 12'h000;
      do_txn(8'($urandom), r0, r1, rnd_delay(), rnd_delay(), 13'h0, 13'h0);
    end

    repeat (4) step();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_raid_encoder.md
Name: hamming_raid_encoder

Overview:
- Write-path counterpart of the read-side Hamming(12,8) decoder.
- Accepts one 8-bit host byte per transaction and encodes it to a 12-bit even-parity Hamming codeword.
- Mirrors the codeword to two drive slots, D0 and D1 (RAID-1). Each slot has its own valid/ack handshake.
- Optional per-slot error-injection masks let the checker/fixer path be exercised. A timeout flags a drive that never acknowledges.

Parameters:
- ACK_TIMEOUT, 16: maximum SEND cycles before aborting; legal range 2..255.
- INJECT_EN, 1: 1 = XOR inj_mask_D0/D1 into each slot's copy at capture; 0 = masks ignored (treated as 0).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- wr_valid  in  1  host byte valid
- wr_data  in  8  host data byte
- wr_ready  out  1  block can accept a byte
- inj_mask_D0  in  12  error-injection mask for D0, sampled at accept
- inj_mask_D1  in  12  error-injection mask for D1, sampled at accept
- enc_data_D0  out  12  codeword to drive D0
- enc_valid_D0  out  1  enc_data_D0 valid
- enc_ack_D0  in  1  D0 has taken the codeword
- enc_data_D1  out  12  codeword to drive D1
- enc_valid_D1  out  1  enc_data_D1 valid
- enc_ack_D1  in  1  D1 has taken the codeword
- encode_done  out  1  one-cycle pulse: both slots acknowledged
- encode_err  out  1  one-cycle pulse: timeout, at least one slot never acknowledged

Behaviour:
- Codeword layout (index 0 = LSB):
  - data bits: [11]=d7, [10]=d6, [9]=d5, [8]=d4, [6]=d3, [5]=d2, [4]=d1, [2]=d0
  - parity bits: [0]=p1=d0^d1^d3^d4^d6; [1]=p2=d0^d2^d3^d5^d6; [3]=p4=d1^d2^d3^d7; [7]=p8=d4^d5^d6^d7
  - A clean codeword gives syndrome 4'b0 at the checker.
- Reset (reset==0 at a rising edge):
  - state=IDLE; enc_data_D0/D1=12'h000; enc_valid_D0/D1=0; encode_done=0; encode_err=0; timeout counter=0.
  - wr_ready=0 during reset and 1 on the first cycle after reset releases.
  - Reset in any state aborts the in-flight transaction; nothing is replayed.
- FSM states: IDLE, SEND, DONE.
  - IDLE:
    - wr_ready=1.
    - On wr_valid&&wr_ready: register enc(wr_data)^mask for each slot, set both enc_valid, clear the counter, go to SEND.
    - Latency: accept at edge N; valid and data are stable from cycle N+1.
  - SEND:
    - wr_ready=0.
    - Each slot holds valid and data until its ack is sampled high while valid=1. That slot's valid then drops, and its data clears to 0 on the next cycle.
    - An ack while valid=0 is ignored.
    - Acks may arrive in either order or in the same cycle.
    - When no slot is outstanding after the edge (last ack sampled), go to DONE with status=ok.
    - The counter increments every SEND cycle. If a slot is still outstanding in the ACK_TIMEOUT-th SEND cycle with no completing ack, both valids drop, both data clear, and the FSM goes to DONE with status=err.
    - An ack arriving in that same final cycle wins: status=ok.
    - Net effect: valid is high for at most ACK_TIMEOUT cycles.
  - DONE:
    - Exactly one cycle: encode_done=1 if ok, else encode_err=1. Both are never high together.
    - wr_ready=0; then go to IDLE.
- All outputs are registered; wr_ready is decoded from the state register.
- Throughput: one byte per (2 + ack-wait) cycles, minimum 3 cycles.
- With INJECT_EN=0, codewords equal enc(wr_data) regardless of the masks.
- wr_data and the masks are sampled only at accept; later changes have no effect.

Decomposition:
- Shared package hamming_pkg:
  - HAM_DATA_W=8, HAM_CODE_W=12
  - parity index constants P1_IDX=0, P2_IDX=1, P4_IDX=3, P8_IDX=7
  - function ham_encode(logic [7:0]) -> logic [11:0], reused by benches and the scoreboard
  - enum enc_state_e {IDLE, SEND, DONE}
- No sub-module needed: parity generation is the package function, and the per-slot handshake is two instances of the same always_ff pattern in this module.

Test Plan:
- wr_data=8'hA5, masks 0, both acks 1 cycle after valid -> enc_data_D0=enc_data_D1=12'hA27; encode_done pulses once; wr_ready high again the cycle after DONE.
- wr_data=8'hFF then 8'h00, back-to-back wr_valid -> codewords 12'hF77 then 12'h000; the second byte is accepted only once back in IDLE.
- wr_data=8'hA5, inj_mask_D1=12'h004, INJECT_EN=1 -> D0=12'hA27, D1=12'hA23. A rerun with INJECT_EN=0 gives D1=12'hA27.
- Ack D0 at cycle 2, ack D1 at cycle 5 -> enc_valid_D0 falls after cycle 2, enc_valid_D1 after cycle 5; encode_done at cycle 6. A stray enc_ack_D0 at cycle 4 is ignored.
- ACK_TIMEOUT=16, enc_ack_D1 never asserted -> enc_valid_D1 high exactly 16 cycles; encode_err pulses, encode_done stays 0. Variant: D1 ack in cycle 16 -> encode_done instead.
- reset=0 for one cycle while in SEND -> all outputs at reset values next cycle; wr_ready=1 after release; no encode_done/encode_err pulse for the aborted byte.
